// File: rtl/pdp8_iot_pkg.sv
// pdp8_iot_pkg: IOT sequencer states, mb_in field positions and dwell helpers.
package pdp8_iot_pkg;
  typedef enum logic [3:0] {IDLE, SETUP, P1, G1, P2, G2, P4, G4, DONE} iot_state_e;
  localparam logic [2:0] IOT_OPCODE = 3'b110;
  localparam int OP_HI = 11;
  localparam int OP_LO = 9;
  localparam int DEV_HI = 8;
  localparam int DEV_LO = 3;
  localparam int EN_HI = 2;
  localparam int EN_IOP4 = 2;
  localparam int EN_IOP2 = 1;
  localparam int EN_IOP1 = 0;
  function automatic iot_state_e next_state(iot_state_e s);
    case (s)
      IDLE:    return SETUP;
      SETUP:   return P1;
      P1:      return G1;
      G1:      return P2;
      P2:      return G2;
      G2:      return P4;
      P4:      return G4;
      G4:      return DONE;
      default: return IDLE;
    endcase
  endfunction
  // Counter load value is dwell-1 so the state lasts exactly dwell cycles.
  function automatic logic [7:0] dwell(iot_state_e s, logic [7:0] pw_m1, logic [7:0] gw_m1);
    return (s == P1 || s == P2 || s == P4) ? pw_m1 : (s == IDLE || s == DONE) ? 8'd0 : gw_m1;
  endfunction
endpackage

// File: rtl/iot_pulse_gen_if.sv
// iot_pulse_gen_if: CPU/peripheral-facing IOT request, pulse and response signals.
interface iot_pulse_gen_if;
  logic        iot_start;
  logic [11:0] mb_in;
  logic        io_skip;
  logic        io_ac_clear;
  logic [5:0]  bmb_dev;
  logic        iop1;
  logic        iop2;
  logic        iop4;
  logic        iot_busy;
  logic        iot_done;
  logic        skip_req;
  logic        ac_clr_req;
  modport master (
    output iot_start, mb_in, io_skip, io_ac_clear,
    input  bmb_dev, iop1, iop2, iop4, iot_busy, iot_done, skip_req, ac_clr_req
  );
  modport slave (
    input  iot_start, mb_in, io_skip, io_ac_clear,
    output bmb_dev, iop1, iop2, iop4, iot_busy, iot_done, skip_req, ac_clr_req
  );
endinterface

// File: rtl/iot_dwell_counter.sv
// iot_dwell_counter: 8-bit loadable down-counter with zero flag, shared by all dwell states.
module iot_dwell_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == 8'd0;
endmodule

// File: rtl/iot_pulse_gen.sv
// iot_pulse_gen: PDP-8/I IOT sequencer producing device select, IOP1/2/4 pulses and sticky skip/AC-clear.
module iot_pulse_gen #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2
) (
  input logic             clk,
  input logic             rst_n,
  iot_pulse_gen_if.slave  bus
);
  import pdp8_iot_pkg::*;
  localparam logic [7:0] PW_M1 = 8'(PULSE_W - 1);
  localparam logic [7:0] GW_M1 = 8'(GAP_W - 1);
  iot_state_e state_q, state_d;
  logic [2:0] en_q, en_d;
  logic [5:0] dev_q, dev_d;
  logic       skip_q, skip_d, acl_q, acl_d;
  logic       accept, pulse, ld, zero;
  logic [7:0] ld_val;
  assign accept = state_q == IDLE && bus.iot_start && bus.mb_in[OP_HI:OP_LO] == IOT_OPCODE;
  assign pulse  = (state_q == P1 && en_q[EN_IOP1]) || (state_q == P2 && en_q[EN_IOP2]) ||
                  (state_q == P4 && en_q[EN_IOP4]);
  iot_dwell_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ld),
    .load_val_i (ld_val),
    .zero_o     (zero)
  );
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    if (state_q == IDLE ? accept : zero) begin
      state_d = next_state(state_q);
      ld      = 1'b1;
    end
    ld_val = dwell(state_d, PW_M1, GW_M1);
    en_d   = accept ? bus.mb_in[EN_HI:0] : en_q;
    dev_d  = accept ? bus.mb_in[DEV_HI:DEV_LO] : dev_q;
    skip_d = accept ? 1'b0 : skip_q | (pulse & bus.io_skip);
    acl_d  = accept ? 1'b0 : acl_q | (pulse & bus.io_ac_clear);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 3'b000;
      dev_q   <= 6'd0;
      skip_q  <= 1'b0;
      acl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      dev_q   <= dev_d;
      skip_q  <= skip_d;
      acl_q   <= acl_d;
    end
  // Outputs decode only registered state, so reset clears them without a clock edge.
  assign bus.bmb_dev    = dev_q;
  assign bus.iop1       = state_q == P1 && en_q[EN_IOP1];
  assign bus.iop2       = state_q == P2 && en_q[EN_IOP2];
  assign bus.iop4       = state_q == P4 && en_q[EN_IOP4];
  assign bus.iot_busy   = state_q != IDLE;
  assign bus.iot_done   = state_q == DONE;
  assign bus.skip_req   = skip_q;
  assign bus.ac_clr_req = acl_q;
endmodule

// File: tb/tb_iot_pulse_gen.sv
// tb_iot_pulse_gen: directed IOT scenarios plus random traffic against a slot-timing model.
module tb_iot_pulse_gen;
  localparam int P = 4;
  localparam int G = 2;
  localparam int T = 4 * G + 3 * P + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  iot_pulse_gen_if bus ();
  iot_pulse_gen #(.PULSE_W(P), .GAP_W(G)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // Model: cycle index k since acceptance; slot n occupies cycles [lo, lo+P).
  bit       m_act;
  int       m_k;
  bit [2:0] m_en;
  bit [5:0] m_dev;
  bit       m_skip, m_acl;
  function automatic bit in_slot(int k, int n);
    int lo = (n + 1) * G + n * P + 1;
    return k >= lo && k < lo + P;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_k = 0; m_en = 0; m_dev = 0; m_skip = 0; m_acl = 0;
    end else if (m_act) begin
      for (int n = 0; n < 3; n++)
        if (m_en[n] && in_slot(m_k, n)) begin
          m_skip |= bus.io_skip;
          m_acl  |= bus.io_ac_clear;
        end
      if (m_k == T) m_act = 0;
      else m_k++;
    end else if (bus.iot_start && bus.mb_in[11:9] == 3'b110) begin
      m_act = 1; m_k = 1; m_en = bus.mb_in[2:0]; m_dev = bus.mb_in[8:3];
      m_skip = 0; m_acl = 0;
    end
  end
  always @(negedge clk) begin
    logic [12:0] act, exp;
    act = {bus.bmb_dev, bus.iop1, bus.iop2, bus.iop4, bus.iot_busy, bus.iot_done, bus.skip_req, bus.ac_clr_req};
    exp = {m_dev, m_act && m_en[0] && in_slot(m_k, 0), m_act && m_en[1] && in_slot(m_k, 1),
           m_act && m_en[2] && in_slot(m_k, 2), m_act, m_act && m_k == T, m_skip, m_acl};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL model_cmp t=%0t dev/iop1/iop2/iop4/busy/done/skip/acl got %b expected %b", $time, act, exp);
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  int first[3], last[3];
  int done_n, done_last, busy_n;
  bit skip_done;
  // Call at posedge+1; cycle 0 is the one carrying iot_start.
  task automatic run(input logic [11:0] mb, input int s_lo, input int s_hi, input int s2, input int s3, input int n);
    logic [2:0] p;
    bus.mb_in = mb; bus.iot_start = 1'b1; bus.io_skip = 1'b0; bus.io_ac_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin first[i] = -1; last[i] = -1; end
    done_n = 0; done_last = -1; busy_n = 0; skip_done = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      p = {bus.iop4, bus.iop2, bus.iop1};
      for (int i = 0; i < 3; i++)
        if (p[i]) begin
          if (first[i] < 0) first[i] = c;
          last[i] = c;
        end
      if (bus.iot_busy) busy_n++;
      if (bus.iot_done) begin done_n++; done_last = c; skip_done = bus.skip_req; end
      @(posedge clk); #1;
      bus.iot_start = (c + 1 == s2) || (c + 1 == s3);
      bus.io_skip = (c + 1 >= s_lo) && (c + 1 <= s_hi);
    end
    bus.iot_start = 1'b0; bus.io_skip = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.iot_start = 0; bus.mb_in = 0; bus.io_skip = 0; bus.io_ac_clear = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.iot_busy, 0);
    chk("reset_dev", bus.bmb_dev, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(12'o6037, -1, -1, -1, -1, 25);
    chk("full_iop1_first", first[0], 3); chk("full_iop1_last", last[0], 6);
    chk("full_iop2_first", first[1], 9); chk("full_iop2_last", last[1], 12);
    chk("full_iop4_first", first[2], 15); chk("full_iop4_last", last[2], 18);
    chk("full_done_cycle", done_last, 21); chk("full_busy_len", busy_n, 21);
    chk("full_dev", bus.bmb_dev, 6'o03);
    run(12'o6402, -1, -1, -1, -1, 25);
    chk("part_iop1", first[0], -1); chk("part_iop4", first[2], -1);
    chk("part_iop2_first", first[1], 9); chk("part_iop2_last", last[1], 12);
    chk("part_dev", bus.bmb_dev, 6'o40);
    run(12'o6031, 4, 5, -1, -1, 32);
    chk("skip_at_done", skip_done, 1);
    chk("skip_held", bus.skip_req, 1);
    run(12'o6031, 7, 8, -1, -1, 25);
    chk("skip_gap_ignored", skip_done, 0);
    run(12'o7200, -1, -1, -1, -1, 10);
    chk("nonio_busy", busy_n, 0); chk("nonio_iop1", first[0], -1);
    run(12'o6037, -1, -1, 8, -1, 25);
    chk("busy_start_done", done_last, 21); chk("busy_start_len", busy_n, 21);
    run(12'o6037, -1, -1, 21, 22, 50);
    chk("b2b_done_n", done_n, 2); chk("b2b_done_last", done_last, 43);
    chk("b2b_busy", busy_n, 42); chk("b2b_iop1_last", last[0], 28);
    bus.mb_in = 12'o6037; bus.iot_start = 1'b1;
    @(posedge clk); #1;
    bus.iot_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rst_pre_iop2", bus.iop2, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_iop2", bus.iop2, 0); chk("rst_busy", bus.iot_busy, 0); chk("rst_dev", bus.bmb_dev, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_resume", bus.iot_busy, 0);
    for (int i = 0; i < 3000; i++) begin
      bus.iot_start = $urandom_range(0, 7) == 0;
      bus.mb_in = {($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b110, 9'($urandom)};
      bus.io_skip = $urandom_range(0, 5) == 0;
      bus.io_ac_clear = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.iot_start = 0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/iot_pulse_gen.md
Name: iot_pulse_gen

Overview:
- Generates the PDP-8/I IOT timing: device-select lines and IOP1/IOP2/IOP4 pulses, in positive logic.
- Sits directly upstream of the M633 negative bus drivers, which invert and drive these signals onto the I/O bus.
- Also collects the peripherals' skip and AC-clear responses and hands them back to the CPU timing/major-state logic.

Parameters:
- PULSE_W, 4: clock cycles each IOP pulse is held high (legal range 1..255).
- GAP_W, 2: clock cycles of setup before IOP1, between pulses, and after IOP4 (legal range 1..255).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- iot_start  input  1  one-cycle request from timing logic: execute the IOT held on mb_in.
- mb_in  input  12  memory buffer; bit 0 = PDP bit 11 (LSB); bits 11:9 = opcode, 8:3 = device, 2 = IOP4, 1 = IOP2, 0 = IOP1 enable.
- io_skip  input  1  peripheral skip response (active high, already inverted from bus).
- io_ac_clear  input  1  peripheral AC-clear response (active high).
- bmb_dev  output  6  latched device select code.
- iop1, iop2, iop4  output  1 each  IOP pulses.
- iot_busy  output  1  sequence in progress.
- iot_done  output  1  one-cycle completion strobe.
- skip_req  output  1  sticky skip result, valid with iot_done.
- ac_clr_req  output  1  sticky AC-clear result, valid with iot_done.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (asynchronous on rst_n low): all outputs 0, bmb_dev = 0, state IDLE, counter 0. This applies mid-sequence too; any pulse in progress drops immediately. No resumption after release.
- Outputs: all registered; no combinational path from inputs to outputs.
- Start acceptance: iot_start is accepted only in IDLE and only when mb_in[11:9] == 3'b110. Otherwise it is ignored and no strobe is issued. iot_start while busy is ignored.
- On accept:
  - latch bmb_dev = mb_in[8:3] and the enables mb_in[2:0];
  - clear skip_req and ac_clr_req;
  - iot_busy = 1 from the next cycle.
- State machine and dwell times:
  - IDLE -> SETUP (GAP_W) -> P1 (PULSE_W) -> G1 (GAP_W) -> P2 (PULSE_W) -> G2 (GAP_W) -> P4 (PULSE_W) -> G4 (GAP_W) -> DONE (1) -> IDLE.
  - One 8-bit down-counter, loaded on each state entry, sets the dwell.
- Pulse outputs:
  - iopN is high exactly during state PN, and only if its enable bit is latched.
  - Disabled slots still elapse, so timing is fixed regardless of the enables.
  - Pulses never overlap.
- Busy/done timing:
  - Total busy length = 4*GAP_W + 3*PULSE_W + 1 cycles (21 at defaults).
  - iot_busy is high for all states except IDLE, including DONE.
  - iot_done is high only in DONE.
- Responses:
  - io_skip and io_ac_clear are sampled every cycle while in any PN state whose enable is set.
  - A sample of 1 sets the corresponding sticky flag.
  - Samples outside enabled pulse states are ignored.
  - Flags hold after DONE until the next accepted start or reset.
- Latched values: bmb_dev holds its value after DONE until the next accept.
- Back-to-back: iot_start in the DONE cycle is ignored. The earliest new accept is the first IDLE cycle.
- Enables = 000: the sequence runs with no pulses. skip_req and ac_clr_req stay 0 and iot_done still fires.

Decomposition:
- Shared package pdp8_iot_pkg:
  - state enum (IDLE, SETUP, P1, G1, P2, G2, P4, G4, DONE);
  - IOT_OPCODE = 3'b110;
  - field position constants for mb_in (opcode, device, enable bits).
- Sub-module iot_dwell_counter: 8-bit loadable down-counter with zero flag, reused for all dwell states. The FSM stays in iot_pulse_gen.

Test Plan:
- Full IOT: PULSE_W=4, GAP_W=2; mb_in=12'o6037, iot_start pulse at cycle 0 -> bmb_dev=6'o03; iop1 high cycles 3-6, iop2 high 9-12, iop4 high 15-18; iot_done high at cycle 21; iot_busy high cycles 1-21.
- Partial enables: mb_in=12'o6402 -> only iop2 pulses, same slot timing as above; iop1 and iop4 stay 0; bmb_dev=6'o40.
- Skip collection:
  - mb_in=12'o6031; io_skip=1 during cycles 4-5 -> skip_req=1 at iot_done, held through 10 idle cycles.
  - Repeat with io_skip=1 only during G1 -> skip_req=0.
- Non-IOT and busy rejection:
  - mb_in=12'o7200 with iot_start -> no busy, no pulses.
  - A second iot_start at cycle 8 of an active IOT -> ignored; timing unchanged.
- Reset mid-pulse: assert rst_n low during P2 cycle 10 -> iop2, iot_busy, bmb_dev at 0 with no clock edge needed; after release, no activity until a new iot_start.
- Back-to-back: iot_start in the DONE cycle ignored; iot_start in the following cycle accepted, and the new sequence shows the identical 21-cycle profile.
